cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among three result producers: ALU, LSB load path and LSB store path.
- Each producer pushes into its own small skid FIFO. A round-robin scheduler drains one result per cycle onto a registered CDB.
- The CDB is read by the RS, LSB and ROB.
- Sits between the execution units and the broadcast consumers, replacing point-to-point broadcast wiring.

---
 rtl/cdb_pkg.sv | 25 ++
 rtl/cdb_src_fifo.sv | 56 +++++
 rtl/cdb_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared constants, payload type and source-index helper for the CDB arbiter
package cdb_pkg;

  localparam logic [1:0] SRC_ALU   = 2'd0;
  localparam logic [1:0] SRC_LOAD  = 2'd1;
  localparam logic [1:0] SRC_STORE = 2'd2;
  localparam int NUM_SRC = 3;

  localparam int DEF_ENTRY_W = 4;
  localparam int DEF_DATA_W  = 32;

  typedef struct packed {
    logic [DEF_ENTRY_W-1:0] entry;
    logic [DEF_DATA_W-1:0]  data;
    logic [DEF_DATA_W-1:0]  aux;
  } cdb_payload;

  // (a + b) mod NUM_SRC for source indices already below NUM_SRC
  function automatic logic [1:0] src_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'(NUM_SRC)) ? 2'(s - 3'(NUM_SRC)) : s[1:0];
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-producer skid FIFO with flush; ready derives from the registered count only
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign ready   = (count != CW'(DEPTH));
  assign do_push = push && ready && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits over a power-of-two depth, so they wrap on their own
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter over ALU/load/store FIFOs with a registered broadcast
// CDB_BYPASS_EN: an empty-FIFO source with valid high may win directly from its inputs.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int ENTRY_W    = DEF_ENTRY_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rollback,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic [DATA_W-1:0]  alu_aux,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [ENTRY_W-1:0] ld_entry,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic [DATA_W-1:0]  ld_aux,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [ENTRY_W-1:0] st_entry,
  input  logic [DATA_W-1:0]  st_data,
  input  logic [DATA_W-1:0]  st_aux,
  output logic               cdb_valid,
  output logic [1:0]         cdb_src,
  output logic [ENTRY_W-1:0] cdb_entry,
  output logic [DATA_W-1:0]  cdb_data,
  output logic [DATA_W-1:0]  cdb_aux
);

  localparam int PL_W  = ENTRY_W + 2 * DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] in_valid;
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [PL_W-1:0]    in_pl   [NUM_SRC];
  logic [PL_W-1:0]    head_pl [NUM_SRC];
  logic [CNT_W-1:0]   count   [NUM_SRC];

  logic [1:0]      rr_ptr;
  logic [1:0]      win;
  logic            grant_any;
  logic            byp_take;
  logic            active;
  logic            flush;
  logic [PL_W-1:0] win_pl;

  assign in_valid         = {st_valid, ld_valid, alu_valid};
  assign in_pl[SRC_ALU]   = {alu_entry, alu_data, alu_aux};
  assign in_pl[SRC_LOAD]  = {ld_entry, ld_data, ld_aux};
  assign in_pl[SRC_STORE] = {st_entry, st_data, st_aux};
  assign alu_ready        = src_ready[SRC_ALU];
  assign ld_ready         = src_ready[SRC_LOAD];
  assign st_ready         = src_ready[SRC_STORE];

  assign active = rdy && !rollback;
  assign flush  = rdy && rollback;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PL_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_pl[i]),
      .dout  (head_pl[i]),
      .count (count[i]),
      .ready (src_ready[i])
    );
    assign fifo_empty[i] = (count[i] == '0);
  end

`ifdef CDB_BYPASS_EN
  assign req      = ~fifo_empty | in_valid;
  assign byp_take = grant_any && fifo_empty[win];
`else
  assign req      = ~fifo_empty;
  assign byp_take = 1'b0;
`endif

  assign win_pl = byp_take ? in_pl[win] : head_pl[win];

  always_comb begin
    grant_any = 1'b0;
    win       = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_any && req[src_add(rr_ptr, 2'(k))]) begin
        grant_any = 1'b1;
        win       = src_add(rr_ptr, 2'(k));
      end
    end
  end

  // A bypassed winner is consumed straight from its inputs, so it must not also land in the FIFO
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = active && grant_any && (win == 2'(i)) && !fifo_empty[i];
      push[i] = active && in_valid[i] && src_ready[i] && !(byp_take && (win == 2'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= SRC_ALU;
      cdb_valid <= 1'b0;
      cdb_src   <= SRC_ALU;
      cdb_entry <= '0;
      cdb_data  <= '0;
      cdb_aux   <= '0;
    end else if (rdy) begin
      if (rollback) begin
        rr_ptr    <= SRC_ALU;
        cdb_valid <= 1'b0;
      end else if (grant_any) begin
        rr_ptr                         <= src_add(win, 2'd1);
        cdb_valid                      <= 1'b1;
        cdb_src                        <= win;
        {cdb_entry, cdb_data, cdb_aux} <= win_pl;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - queue-model bench for cdb_arbiter; follows CDB_BYPASS_EN for expected latency
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  logic in_valid [3];
  cdb_payload in_pl [3];

  logic        alu_ready, ld_ready, st_ready, cdb_valid;
  logic [1:0]  cdb_src;
  logic [3:0]  cdb_entry;
  logic [31:0] cdb_data, cdb_aux;

  always #5 clk = ~clk;

  cdb_arbiter #(.ENTRY_W(4), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(in_valid[0]), .alu_ready(alu_ready), .alu_entry(in_pl[0].entry),
    .alu_data(in_pl[0].data), .alu_aux(in_pl[0].aux),
    .ld_valid(in_valid[1]), .ld_ready(ld_ready), .ld_entry(in_pl[1].entry),
    .ld_data(in_pl[1].data), .ld_aux(in_pl[1].aux),
    .st_valid(in_valid[2]), .st_ready(st_ready), .st_entry(in_pl[2].entry),
    .st_data(in_pl[2].data), .st_aux(in_pl[2].aux),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_entry(cdb_entry),
    .cdb_data(cdb_data), .cdb_aux(cdb_aux)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: one queue per producer, a rotating start index, and the broadcast register
  cdb_payload q [3][$];
  int         rr = 0;
  logic       m_valid = 1'b0;
  logic [1:0] m_src = 2'd0;
  cdb_payload m_pl = '0;
  bit         edge_rdy = 1'b0;
  int         acc_cnt = 0;
  int         bc_cnt = 0;
  bit         rd_m [3];
  int         win;
  bit         byp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      rr = 0; m_valid = 1'b0; m_src = 2'd0; m_pl = '0; edge_rdy = 1'b0;
    end else begin
      edge_rdy = rdy;
      if (rdy) begin
        for (int i = 0; i < 3; i++) rd_m[i] = (q[i].size() != DEPTH);
        if (rollback) begin
          for (int i = 0; i < 3; i++) q[i].delete();
          m_valid = 1'b0;
          rr = 0;
        end else begin
          win = -1;
          byp = 1'b0;
          for (int k = 0; k < 3; k++) begin
            int s;
            s = (rr + k) % 3;
            if (win < 0 && (q[s].size() > 0 || (BYP && in_valid[s]))) win = s;
          end
          if (win >= 0) begin
            if (q[win].size() > 0) m_pl = q[win].pop_front();
            else begin m_pl = in_pl[win]; byp = 1'b1; end
            m_valid = 1'b1;
            m_src = 2'(win);
            rr = (win + 1) % 3;
          end else begin
            m_valid = 1'b0;
          end
          for (int i = 0; i < 3; i++) begin
            if (in_valid[i] && rd_m[i]) begin
              acc_cnt++;
              if (!(byp && win == i)) q[i].push_back(in_pl[i]);
            end
          end
        end
      end
    end
  end

  function automatic logic [73:0] exp_vec();
    return {m_valid, m_src, m_pl, q[0].size() != DEPTH, q[1].size() != DEPTH, q[2].size() != DEPTH};
  endfunction

  wire [73:0] got_vec = {cdb_valid, cdb_src, cdb_entry, cdb_data, cdb_aux, alu_ready, ld_ready, st_ready};

  always @(negedge clk) begin
    if (rst) begin
      logic [73:0] e;
      e = exp_vec();
      checks++;
      if (got_vec !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got v=%0b src=%0d e=%0d d=%h a=%h rdy=%b%b%b required v=%0b src=%0d e=%0d d=%h a=%h rdy=%b",
                 $time, cdb_valid, cdb_src, cdb_entry, cdb_data, cdb_aux, alu_ready, ld_ready, st_ready,
                 e[73], e[72:71], e[70:67], e[66:35], e[34:3], e[2:0]);
      end
      if (cdb_valid && edge_rdy) bc_cnt++;
    end
  end

  task automatic check(input string nm, input logic [73:0] got, input logic [73:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    rollback = 1'b0;
  endtask

  task automatic drive(input int s, input logic [3:0] e, input logic [31:0] d, input logic [31:0] a);
    in_valid[s] = 1'b1;
    in_pl[s].entry = e;
    in_pl[s].data = d;
    in_pl[s].aux = a;
  endtask

  task automatic drive_all(input int n);
    for (int s = 0; s < 3; s++) drive(s, 4'(n * 3 + s), 32'((s << 8) | n), 32'h1000 + 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int prev;
    bit have_prev;
    bit seen_full;
    int rot_err;
    logic [73:0] snap;

    for (int i = 0; i < 3; i++) in_pl[i] = '0;
    idle();

    // Reset state
    @(negedge clk);
    check("rst_cdb", {cdb_valid, cdb_src, cdb_entry, cdb_data, cdb_aux}, '0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_ready", {alu_ready, ld_ready, st_ready}, 3'b111);

    // Single ALU push
    drive(0, 4'd3, 32'h0000_0005, 32'h1004);
    @(negedge clk);
    idle();
    for (int c = 1; c <= 3; c++) begin
      check("t1_valid", cdb_valid, (c == LAT));
      if (cdb_valid) begin
        check("t1_src", cdb_src, 0);
        check("t1_entry", cdb_entry, 3);
        check("t1_data", cdb_data, 5);
        check("t1_aux", cdb_aux, 32'h1004);
      end
      @(negedge clk);
    end

    // rr back to ALU, then all three push together
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    drive(0, 4'd1, 32'h11, 32'hA1);
    drive(1, 4'd2, 32'h22, 32'hA2);
    drive(2, 4'd3, 32'h33, 32'hA3);
    @(negedge clk);
    idle();
    for (int c = 1; c <= LAT + 3; c++) begin
      check("t2_valid", cdb_valid, (c >= LAT && c <= LAT + 2));
      if (c >= LAT && c <= LAT + 2) begin
        check("t2_src", cdb_src, c - LAT);
        check("t2_entry", cdb_entry, c - LAT + 1);
      end
      @(negedge clk);
    end

    // Back-pressure with every producer pushing every cycle
    acc_cnt = 0; bc_cnt = 0; have_prev = 0; seen_full = 0; rot_err = 0; prev = 0;
    for (int n = 0; n < 15; n++) begin
      drive_all(n);
      @(negedge clk);
      if (!alu_ready) seen_full = 1'b1;
      if (cdb_valid) begin
        if (have_prev && cdb_src != 2'((prev + 1) % 3)) rot_err++;
        prev = cdb_src;
        have_prev = 1'b1;
      end
    end
    idle();
    repeat (10) @(negedge clk);
    check("bp_alu_full_seen", seen_full, 1);
    check("bp_rotation", rot_err, 0);
    check("bp_no_loss", bc_cnt, acc_cnt);

    // Rollback with full FIFOs and a live broadcast; same-cycle inputs must be dropped
    for (int n = 0; n < 3; n++) begin
      drive_all(n + 20);
      @(negedge clk);
    end
    check("rb_pre_valid", cdb_valid, 1);
    rollback = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 4'hE, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    idle();
    check("rb_valid", cdb_valid, 0);
    check("rb_ready", {alu_ready, ld_ready, st_ready}, 3'b111);
    drive(0, 4'd7, 32'h77, 32'h7007);
    @(negedge clk);
    idle();
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      if (cdb_valid && lat == 0) begin
        lat = c;
        check("rb_first_entry", cdb_entry, 7);
        check("rb_first_src", cdb_src, 0);
      end
      @(negedge clk);
    end
    check("rb_first_lat", lat, LAT);

    // rdy low for 5 cycles while data is queued and a broadcast is live
    drive_all(5);
    @(negedge clk);
    drive_all(6);
    @(negedge clk);
    check("frz_pre_valid", cdb_valid, 1);
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 4'hF, 32'hBAD, 32'hBAD);
    snap = exp_vec();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("frz_hold", got_vec, snap);
    end
    rdy = 1'b1;
    idle();
    repeat (8) @(negedge clk);

    // Async reset during a broadcast
    drive(1, 4'd9, 32'h99, 32'h9009);
    @(negedge clk);
    idle();
    for (int c = 1; c < 4 && !cdb_valid; c++) @(negedge clk);
    check("arst_pre_valid", cdb_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", cdb_valid, 0);
    check("arst_entry", cdb_entry, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
